inst_prefetch_unit: RTL

Parametrised instruction-fetch front end for the MIPS CPU: owns the PC, issues instruction-memory reads with a valid handshake tolerating variable memory latency, and buffers fetched instructions with their PCs in a DEPTH-entry FIFO. It adds memory stalls, prefetch buffering, consumer back-pressure and redirect/flush on jumps and branches. It sits between instruction memory and the decode/control stage, and is gated by the debug controller's `cpu_en`.

---
 rtl/inst_prefetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit: instruction-fetch front end for the MIPS CPU.
// Owns the fetch PC and keeps at most one instruction-memory read in flight.
// Returned instructions and their PCs are buffered in a DEPTH-entry FIFO
// for the decode stage. Redirects flush the FIFO and mark any in-flight
// response as stale, so it is dropped when it comes back.
module inst_prefetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    cpu_rst,
  input  logic                    cpu_en,
  output logic                    inst_ren,
  output logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic                    inst_valid,
  input  logic [DATA_WIDTH-1:0]   inst_data,
  input  logic                    redirect_en,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_inst,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  pending;
  logic                  discard;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  slot_free;
  logic [CNT_W:0]        reserved;
  logic                  issue;
  logic                  resp;
  logic                  redir;
  logic                  push;
  logic                  pop;

  // Request, response, push and pop qualifiers. A slot in the FIFO is
  // reserved for the outstanding request so a push can never overflow.
  always_comb begin
    slot_free = !pending || inst_valid;
    reserved  = {1'b0, count} + {{CNT_W{1'b0}}, pending};
    redir     = redirect_en && cpu_en;
    resp      = inst_valid && pending;
    issue     = cpu_en && !cpu_rst && !redirect_en && slot_free && (reserved < DEPTH_EXT);
    push      = resp && !discard && !redir && !cpu_rst;
    pop       = out_valid && out_ready && cpu_en && !redir && !cpu_rst;
  end

  assign inst_ren  = issue;
  assign inst_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_inst  = inst_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign occupancy = count;

  // FIFO payload storage; entries need no reset because count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= inst_data;
    end
  end

  // PC, request tracking and FIFO bookkeeping; redirect outranks everything.
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      fetch_pc <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
      pending  <= 1'b0;
      discard  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redir) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pending  <= pending && !inst_valid;
      discard  <= pending && !inst_valid;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        req_pc   <= fetch_pc;
        pending  <= 1'b1;
      end else if (resp) begin
        pending  <= 1'b0;
      end
      if (resp && discard) begin
        discard <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
